// File: rtl/gray_window_3x3.sv
// 3x3 sliding-window generator for a raster grayscale stream.
// Two line buffers plus a 3x3 shift register; windows are emitted only when all nine taps belong to the current frame.
module gray_window_3x3 #(
    parameter int WIDTH = 8,
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   data_in,
    input  logic               data_in_done,
    input  logic               sof,
    output logic [9*WIDTH-1:0] window_out,
    output logic               window_valid,
    output logic               frame_done
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    logic [CW-1:0]      col_q, col_d, cur_col;
    logic [RW-1:0]      row_q, row_d, cur_row;
    logic [9*WIDTH-1:0] win_q, win_d, win_shift;
    logic [9*WIDTH-1:0] window_out_q, window_out_d;
    logic               window_valid_q, window_valid_d;
    logic               frame_done_q, frame_done_d;

    logic [WIDTH-1:0]   line1_mem [0:IMG_W-1];  // line row-1
    logic [WIDTH-1:0]   line2_mem [0:IMG_W-1];  // line row-2
    logic [WIDTH-1:0]   line1_rd, line2_rd;

    // sof forces the current pixel to (0,0) regardless of where the counters are
    assign cur_col  = sof ? '0 : col_q;
    assign cur_row  = sof ? '0 : row_q;
    assign line1_rd = line1_mem[cur_col];
    assign line2_rd = line2_mem[cur_col];

    always_ff @(posedge clk) begin
        if (data_in_done) begin
            line1_mem[cur_col] <= data_in;
            line2_mem[cur_col] <= line1_rd;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_row
            assign win_shift[WIDTH*(3*gi)   +: WIDTH] = win_q[WIDTH*(3*gi+1) +: WIDTH];
            assign win_shift[WIDTH*(3*gi+1) +: WIDTH] = win_q[WIDTH*(3*gi+2) +: WIDTH];
        end
    endgenerate
    assign win_shift[WIDTH*2 +: WIDTH] = line2_rd;
    assign win_shift[WIDTH*5 +: WIDTH] = line1_rd;
    assign win_shift[WIDTH*8 +: WIDTH] = data_in;

    always_comb begin
        col_d          = col_q;
        row_d          = row_q;
        win_d          = win_q;
        window_out_d   = window_out_q;
        window_valid_d = 1'b0;
        frame_done_d   = 1'b0;
        if (data_in_done) begin
            win_d = win_shift;
            if (cur_col == COL_LAST) begin
                col_d = '0;
                row_d = (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
            end else begin
                col_d = cur_col + CW'(1);
                row_d = cur_row;
            end
            // x>=2 keeps windows from straddling a line wrap; y>=2 hides stale line-buffer data
            window_valid_d = (cur_row >= RW'(2)) && (cur_col >= CW'(2));
            if (window_valid_d) begin
                window_out_d = win_shift;
            end
            frame_done_d = (cur_row == ROW_LAST) && (cur_col == COL_LAST);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col_q          <= '0;
            row_q          <= '0;
            win_q          <= '0;
            window_out_q   <= '0;
            window_valid_q <= 1'b0;
            frame_done_q   <= 1'b0;
        end else begin
            col_q          <= col_d;
            row_q          <= row_d;
            win_q          <= win_d;
            window_out_q   <= window_out_d;
            window_valid_q <= window_valid_d;
            frame_done_q   <= frame_done_d;
        end
    end

    assign window_out   = window_out_q;
    assign window_valid = window_valid_q;
    assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_gray_window_3x3.sv
// Self-checking bench for gray_window_3x3 on a 4x4 image: directed table, corner sequences, random stream vs. pixel-map model.
module tb_gray_window_3x3;
    localparam int W = 4;
    localparam int H = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  data_in;
    logic        data_in_done;
    logic        sof;
    logic [71:0] window_out;
    logic        window_valid;
    logic        frame_done;

    gray_window_3x3 #(.WIDTH(8), .IMG_W(W), .IMG_H(H)) dut (
        .clk          (clk),
        .reset        (reset),
        .data_in      (data_in),
        .data_in_done (data_in_done),
        .sof          (sof),
        .window_out   (window_out),
        .window_valid (window_valid),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;
    int win_cnt = 0;
    int fd_cnt = 0;

    // Model: a picture of the current frame indexed by (y,x) plus a raster position.
    logic [7:0]  pix [H][W];
    int          my = 0;
    int          mx = 0;
    logic [71:0] exp_hold = '0;

    typedef struct {
        bit sof;
        int data;
        bit exp_valid;
        bit exp_fd;
        int exp_base;
    } vec_t;
    vec_t tbl [16];

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] req);
        tests_run++;
        if (act !== req) begin
            tests_failed++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [71:0] win_from_base(input int b);
        logic [71:0] w;
        w = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                w[8*(3*r+c) +: 8] = 8'(b + 4*r + c);
        return w;
    endfunction

    task automatic model_reset();
        my = 0;
        mx = 0;
        exp_hold = '0;
    endtask

    // Drive one cycle, advance the model, then compare outputs just after the edge.
    task automatic step(input bit done, input bit s, input int d);
        bit ev, ef;
        int cy, cx;
        ev = 0;
        ef = 0;
        data_in_done = done;
        sof = s;
        data_in = 8'(d);
        if (done) begin
            cy = s ? 0 : my;
            cx = s ? 0 : mx;
            pix[cy][cx] = 8'(d);
            if (cy >= 2 && cx >= 2) begin
                ev = 1;
                for (int r = 0; r < 3; r++)
                    for (int c = 0; c < 3; c++)
                        exp_hold[8*(3*r+c) +: 8] = pix[cy-2+r][cx-2+c];
            end
            ef = (cy == H-1) && (cx == W-1);
            mx = cx + 1;
            my = cy;
            if (mx == W) begin
                mx = 0;
                my = (cy + 1 == H) ? 0 : cy + 1;
            end
        end
        @(posedge clk);
        #1;
        chk("window_valid", 72'(window_valid), 72'(ev));
        chk("frame_done", 72'(frame_done), 72'(ef));
        chk("window_out", window_out, exp_hold);
        if (window_valid) win_cnt++;
        if (frame_done) fd_cnt++;
        data_in_done = 1'b0;
        sof = 1'b0;
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_window_out"}, window_out, '0);
        chk({name, "_window_valid"}, 72'(window_valid), '0);
        chk({name, "_frame_done"}, 72'(frame_done), '0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) tbl[i] = '{i == 0, i, 1'b0, 1'b0, -1};
        tbl[10] = '{1'b0, 10, 1'b1, 1'b0, 0};
        tbl[11] = '{1'b0, 11, 1'b1, 1'b0, 1};
        tbl[14] = '{1'b0, 14, 1'b1, 1'b0, 4};
        tbl[15] = '{1'b0, 15, 1'b1, 1'b1, 5};

        reset = 1'b0;
        data_in = '0;
        data_in_done = 1'b0;
        sof = 1'b0;
        #3;
        chk_zero("reset");
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();

        // Contiguous frame with sof, checked against the table
        win_cnt = 0; fd_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            step(1, tbl[i].sof, tbl[i].data);
            chk($sformatf("tbl_valid_%0d", i), 72'(window_valid), 72'(tbl[i].exp_valid));
            chk($sformatf("tbl_fd_%0d", i), 72'(frame_done), 72'(tbl[i].exp_fd));
            if (tbl[i].exp_valid)
                chk($sformatf("tbl_win_%0d", i), window_out, win_from_base(tbl[i].exp_base));
        end
        chk("frame1_windows", 72'(win_cnt), 72'(4));
        chk("frame1_done", 72'(fd_cnt), 72'(1));
        $display("[TB] contiguous frame: windows=%0d frame_done=%0d", win_cnt, fd_cnt);

        // Same frame with a gap after every pixel
        win_cnt = 0; fd_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            step(1, i == 0, i);
            step(0, 0, 8'hEE);
        end
        chk("gapped_windows", 72'(win_cnt), 72'(4));
        chk("gapped_last_win", window_out, win_from_base(5));
        $display("[TB] gapped frame: windows=%0d frame_done=%0d", win_cnt, fd_cnt);

        // Aborted frame followed by a new frame
        win_cnt = 0; fd_cnt = 0;
        for (int i = 0; i < 7; i++) step(1, i == 0, 50 + i);
        for (int i = 0; i < 16; i++) begin
            step(1, i == 0, 100 + i);
            if (i == 10) chk("abort_first_win", window_out, win_from_base(100));
        end
        chk("abort_windows", 72'(win_cnt), 72'(4));
        chk("abort_frame_done", 72'(fd_cnt), 72'(1));
        $display("[TB] aborted frame: windows=%0d frame_done=%0d", win_cnt, fd_cnt);

        // Reset mid-frame, then a frame without sof
        for (int i = 0; i < 10; i++) step(1, i == 0, 30 + i);
        reset = 1'b0;
        model_reset();
        #1;
        chk_zero("midreset");
        @(posedge clk);
        #1;
        chk_zero("midreset_hold");
        reset = 1'b1;
        win_cnt = 0; fd_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            step(1, 0, i);
            if (i == 10) chk("postreset_first_win", window_out, win_from_base(0));
        end
        chk("postreset_windows", 72'(win_cnt), 72'(4));
        chk("postreset_frame_done", 72'(fd_cnt), 72'(1));
        $display("[TB] post-reset frame: windows=%0d frame_done=%0d", win_cnt, fd_cnt);

        // Back-to-back frames
        win_cnt = 0; fd_cnt = 0;
        for (int i = 0; i < 32; i++) begin
            step(1, (i % 16) == 0, (i < 16) ? i : 200 + i - 16);
            if (i == 26) chk("b2b_second_first_win", window_out, win_from_base(200));
        end
        chk("b2b_windows", 72'(win_cnt), 72'(8));
        chk("b2b_frame_done", 72'(fd_cnt), 72'(2));
        $display("[TB] back-to-back frames: windows=%0d frame_done=%0d", win_cnt, fd_cnt);

        // Random stream with gaps and occasional sof
        win_cnt = 0; fd_cnt = 0;
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0, int'($urandom_range(0, 255)));
        $display("[TB] random stream: windows=%0d frame_done=%0d", win_cnt, fd_cnt);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
